mem_arbiter: RTL
================

# mem_arbiter

Shares the single p18240 memory port between the CPU (controlpath/datapath) and a secondary debug/loader requester. It sits between the CPU's memory strobes and `memorySystem`. The CPU has fixed priority. The debug port is served in CPU-idle cycles. A starvation counter stalls the CPU for one cycle so that a waiting debug request always completes within a bounded time.

## Interface

- `WAIT_MAX`, default 8: number of consecutive blocked cycles before a forced debug slot (≥2).
- `AW`, default 16: address width.
- `DW`, default 16: data width.

- `clock`  in  1: single clock; all state updates on posedge.
- `reset`  in  1: one clock; reset is synchronous and active-high.
- `cpu_re_L`, `cpu_we_L`  in  1 each: CPU read/write strobes, active-low.
- `cpu_addr`  in  AW: CPU address.
- `cpu_wdata`  in  DW: CPU write data.
- `cpu_rdata`  out  DW: read data returned to the CPU.
- `cpu_stall`  out  1: controlpath holds its state this cycle; the CPU access is not performed.
- `dbg_req`  in  1: debug access request.
- `dbg_we`  in  1: 1 = write, 0 = read.
- `dbg_addr`  in  AW: debug address.
- `dbg_wdata`  in  DW: debug write data.
- `dbg_gnt`  out  1: debug access is performed this cycle.
- `dbg_rdata`  out  DW: registered debug read data.
- `dbg_rvalid`  out  1: one-cycle pulse; `dbg_rdata` is valid.
- `mem_addr`  out  AW: address to memory.
- `mem_wdata`  out  DW: write data to memory.
- `mem_re_L`, `mem_we_L`  out  1 each: memory strobes, active-low.
- `mem_rdata`  in  DW: combinational read data from memory.

## Operation

- **CPU access:** `cpu_re_L==0` or `cpu_we_L==0`. If both are low, treat it as a write and suppress the read.
- **States:** `ARB` (normal) and `FORCE` (one stolen cycle).
- **Owner each cycle (combinational):**
  - `reset` high: none.
  - `FORCE`: debug.
  - CPU access present: CPU.
  - `dbg_req`: debug.
  - Otherwise: none.
- **Owner none:** both memory strobes high, `mem_addr`=`cpu_addr`, `mem_wdata`=`cpu_wdata`.
- **Owner debug:** memory strobes derived from `dbg_we`, `dbg_gnt`=1, `cpu_stall`=(state==`FORCE`).
- **Read data:** `cpu_rdata` = `mem_rdata` at all times. The CPU samples it only when it owns the port.
- **Wait counter `wcnt`:**
  - Cleared when `dbg_req`=0, on any grant, or on reset.
  - Otherwise increments each cycle the debug request is blocked by the CPU; saturates at `WAIT_MAX-1`.
- **ARB → FORCE:** when `wcnt==WAIT_MAX-1`, the debug request is blocked this cycle, and `reset`=0.
- **FORCE → ARB:** always, after exactly one cycle.
- **Debug handshake:**
  - Hold `dbg_req`/`dbg_we`/`dbg_addr`/`dbg_wdata` stable until the cycle `dbg_gnt`=1.
  - Drop `dbg_req` the cycle after the grant, or keep it high to issue the next access.
  - Dropping `dbg_req` before a grant aborts the request: no memory access, `wcnt` cleared. In `FORCE` the grant is still issued only if `dbg_req`=1. If `dbg_req`=0 the stolen cycle idles.
- **Debug read:** at the posedge ending a granted read, `dbg_rdata` ← `mem_rdata`. `dbg_rvalid`=1 for the following cycle only.
- **Reset values:**
  - State `ARB`, `wcnt`=0.
  - `dbg_rdata`=0, `dbg_rvalid`=0, `cpu_stall`=0, `dbg_gnt`=0.
  - `mem_re_L`=`mem_we_L`=1 while `reset` is high.
- **Reset mid-FORCE:** the stolen cycle is abandoned, with no memory strobe. The next cycle is `ARB` with `wcnt`=0.

## Timing

- **CPU path:** purely combinational; zero added latency. The CPU sees at most one stall cycle per `WAIT_MAX+1` cycles.
- **Debug grant latency:**
  - 0 cycles if the CPU is idle.
  - If the request rises in cycle 0 and the CPU is busy every cycle, `dbg_gnt` arrives in cycle `WAIT_MAX` (the `FORCE` cycle).
- **Debug read data:** `dbg_rvalid` one cycle after the grant.
- **Back-to-back forced slots:** separated by at least `WAIT_MAX` CPU-owned cycles, because `wcnt` restarts from 0.
- **Writes:** committed by `memorySystem` at the posedge ending the strobe cycle.

## Structure

- Add `arb_state_t` {`ARB`, `FORCE`} and `owner_t` {`OWN_NONE`, `OWN_CPU`, `OWN_DBG`} to `constants.sv`.
- One sub-module: `mem_arb_wait_counter`. It implements the saturating `wcnt` with clear, increment and `at_max` output, parameterized by `WAIT_MAX`.
- Top-level integration:
  - Wire `cpu_stall` into controlpath as a state-hold enable.
  - Route `memAddr` and the strobes through this block.
  - `memorySystem` is untouched.

## Test plan

1. **CPU-only read:** CPU read at 0x0010, memory returns 0xBEEF → `mem_re_L`=0 same cycle, `mem_addr`=0x0010, `cpu_rdata`=0xBEEF, `cpu_stall`=0, `dbg_gnt`=0.
2. **Idle-slot debug write:** CPU idle, debug write of 0x1234 to 0x0100 → `dbg_gnt`=1 same cycle, `mem_we_L`=0, `mem_addr`=0x0100, `mem_wdata`=0x1234.
3. **Contention:** `WAIT_MAX`=8, CPU reads every cycle, debug read of 0x0200 (memory holds 0xCAFE) from cycle 0 →
   - `dbg_gnt`=0 in cycles 0–7.
   - Cycle 8: `cpu_stall`=1, `dbg_gnt`=1, `mem_addr`=0x0200.
   - Cycle 9: `dbg_rvalid`=1 with `dbg_rdata`=0xCAFE, `cpu_stall`=0.
   - Next forced slot no earlier than cycle 17.
4. **Early abort:** debug request dropped in cycle 5 of contention → no grant, `wcnt`=0, no stall in cycles 6–8.
5. **Reset in FORCE:** `reset` high during the `FORCE` cycle → both memory strobes high that cycle. Next cycle: `cpu_stall`=0, `dbg_rvalid`=0, state `ARB`, `wcnt`=0.
6. **Both CPU strobes low:** CPU asserts `re_L` and `we_L` together at 0x0030 → only `mem_we_L`=0, `mem_re_L`=1.

Source files
------------

// File: rtl/mem_arbiter_pkg.sv
// Shared types and helpers for the memory-port arbiter between the CPU and the debug requester.
package mem_arbiter_pkg;

    typedef enum logic {
        ARB   = 1'b0,
        FORCE = 1'b1
    } arb_state_t;

    typedef enum logic [1:0] {
        OWN_NONE = 2'd0,
        OWN_CPU  = 2'd1,
        OWN_DBG  = 2'd2
    } owner_t;

    // Width of a counter that must reach wait_max-1.
    function automatic int unsigned wcnt_width(input int unsigned wait_max);
        return (wait_max <= 2) ? 1 : $clog2(wait_max);
    endfunction

endpackage

// File: rtl/mem_arb_wait_counter.sv
// Saturating count of consecutive cycles a debug request has been blocked by the CPU.
module mem_arb_wait_counter
    import mem_arbiter_pkg::*;
#(
    parameter int unsigned WAIT_MAX = 8,
    localparam int unsigned CW = wcnt_width(WAIT_MAX)
) (
    input  logic          clk_i,
    input  logic          rst_i,
    input  logic          clr_i,
    input  logic          inc_i,
    output logic [CW-1:0] wcnt_o,
    output logic          at_max_o
);

    localparam logic [CW-1:0] MaxVal = CW'(WAIT_MAX - 1);

    logic [CW-1:0] wcnt_d, wcnt_q;

    always_comb begin
        wcnt_d = wcnt_q;
        if (clr_i) begin
            wcnt_d = '0;
        end else if (inc_i && (wcnt_q != MaxVal)) begin
            wcnt_d = wcnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wcnt_q <= '0;
        end else begin
            wcnt_q <= wcnt_d;
        end
    end

    assign wcnt_o   = wcnt_q;
    assign at_max_o = (wcnt_q == MaxVal);

endmodule

// File: rtl/mem_arbiter.sv
// Shares the single memory port between the CPU (fixed priority) and a debug/loader requester,
// stealing one CPU cycle when the debug request has been blocked for WAIT_MAX cycles.
module mem_arbiter
    import mem_arbiter_pkg::*;
#(
    parameter int unsigned WAIT_MAX = 8,
    parameter int unsigned AW       = 16,
    parameter int unsigned DW       = 16
) (
    input  logic          clock,
    input  logic          reset,

    input  logic          cpu_re_L,
    input  logic          cpu_we_L,
    input  logic [AW-1:0] cpu_addr,
    input  logic [DW-1:0] cpu_wdata,
    output logic [DW-1:0] cpu_rdata,
    output logic          cpu_stall,

    input  logic          dbg_req,
    input  logic          dbg_we,
    input  logic [AW-1:0] dbg_addr,
    input  logic [DW-1:0] dbg_wdata,
    output logic          dbg_gnt,
    output logic [DW-1:0] dbg_rdata,
    output logic          dbg_rvalid,

    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_wdata,
    output logic          mem_re_L,
    output logic          mem_we_L,
    input  logic [DW-1:0] mem_rdata
);

    localparam int unsigned CW = wcnt_width(WAIT_MAX);

    arb_state_t    state_d, state_q;
    owner_t        owner;
    logic          cpu_acc;
    logic          dbg_blocked;
    logic          wcnt_clr;
    logic          wcnt_at_max;
    logic [CW-1:0] wcnt;
    logic [DW-1:0] dbg_rdata_q;
    logic          dbg_rvalid_q;

    assign cpu_acc = ~cpu_re_L | ~cpu_we_L;

    always_comb begin
        owner = OWN_NONE;
        if (reset) begin
            owner = OWN_NONE;
        end else if (state_q == FORCE) begin
            // An aborted request leaves the stolen cycle idle.
            owner = dbg_req ? OWN_DBG : OWN_NONE;
        end else if (cpu_acc) begin
            owner = OWN_CPU;
        end else if (dbg_req) begin
            owner = OWN_DBG;
        end
    end

    always_comb begin
        mem_addr  = cpu_addr;
        mem_wdata = cpu_wdata;
        mem_re_L  = 1'b1;
        mem_we_L  = 1'b1;
        unique case (owner)
            OWN_CPU: begin
                // Both CPU strobes low is a write; the read is suppressed.
                mem_we_L = cpu_we_L;
                mem_re_L = cpu_re_L | ~cpu_we_L;
            end
            OWN_DBG: begin
                mem_addr  = dbg_addr;
                mem_wdata = dbg_wdata;
                mem_we_L  = ~dbg_we;
                mem_re_L  = dbg_we;
            end
            default: begin
            end
        endcase
    end

    assign dbg_gnt     = (owner == OWN_DBG);
    assign cpu_stall   = (state_q == FORCE) & ~reset;
    assign cpu_rdata   = mem_rdata;
    assign dbg_blocked = dbg_req & (owner == OWN_CPU);
    assign wcnt_clr    = ~dbg_req | dbg_gnt;

    mem_arb_wait_counter #(
        .WAIT_MAX (WAIT_MAX)
    ) u_wait_counter (
        .clk_i    (clock),
        .rst_i    (reset),
        .clr_i    (wcnt_clr),
        .inc_i    (dbg_blocked),
        .wcnt_o   (wcnt),
        .at_max_o (wcnt_at_max)
    );

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ARB:     if (wcnt_at_max && dbg_blocked) state_d = FORCE;
            FORCE:   state_d = ARB;
            default: state_d = ARB;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q      <= ARB;
            dbg_rvalid_q <= 1'b0;
            dbg_rdata_q  <= '0;
        end else begin
            state_q      <= state_d;
            dbg_rvalid_q <= dbg_gnt & ~dbg_we;
            if (dbg_gnt && !dbg_we) begin
                dbg_rdata_q <= mem_rdata;
            end
        end
    end

    assign dbg_rdata  = dbg_rdata_q;
    assign dbg_rvalid = dbg_rvalid_q;

    // Observed only through the saturation flag; the full count stays visible for debug.
    logic unused_wcnt;
    assign unused_wcnt = ^wcnt;

endmodule
